// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//   Computes diff = a - b - borrow_in on WIDTH-bit operands, DIGIT bits per
//   clock, carrying the borrow between digits in a register.
//   An operation takes NDIG = WIDTH/DIGIT RUN cycles.
//   Ports:
//     clk, rst        rising-edge clock, asynchronous active-high reset
//     in_valid/ready  operand handshake (a, b, borrow_in); in_ready is
//                     combinational from out_ready
//     out_valid/ready result handshake (diff, borrow_out, overflow)
//     busy            high while the subtraction is running
module digit_serial_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW   = DIGIT + 1;

  // Reject operand widths that do not split into whole digits.
  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [WIDTH-1:0]  a_sh_q,      a_sh_d;
  logic [WIDTH-1:0]  b_sh_q,      b_sh_d;
  logic [WIDTH-1:0]  res_q,       res_d;
  logic              breg_q,      breg_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic              a_msb_q,     a_msb_d;
  logic              b_msb_q,     b_msb_d;
  logic [WIDTH-1:0]  diff_q,      diff_d;
  logic              bout_q,      bout_d;
  logic              ovf_q,       ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q,      busy_d;

  logic                   accept;
  logic [DW-1:0]          dig_sub;
  logic [DIGIT-1:0]       dig_d;
  logic                   dig_bnext;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shifted;

  // Ready when idle, or when the held result is being consumed this cycle.
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // One digit of subtraction; the extra MSB of the DW-bit result is the borrow.
  assign dig_sub   = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]} - DW'(breg_q);
  assign dig_d     = dig_sub[DIGIT-1:0];
  assign dig_bnext = dig_sub[DIGIT];

  // New digit enters at the top of the result; also covers NDIG == 1.
  assign res_cat     = {dig_d, res_q};
  assign res_shifted = res_cat[WIDTH+DIGIT-1:DIGIT];

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    breg_d      = breg_q;
    cnt_d       = cnt_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        res_d  = res_shifted;
        breg_d = dig_bnext;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = S_DONE;
          diff_d  = res_shifted;
          bout_d  = dig_bnext;
          // Signed overflow: operand signs differ and result sign differs from a.
          ovf_d   = (a_msb_q ^ b_msb_q) & (dig_d[DIGIT-1] ^ a_msb_q);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept is only possible in IDLE or DONE, so it never collides with RUN.
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      breg_d  = borrow_in;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      cnt_d   = '0;
      state_d = S_RUN;
    end

    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      breg_q      <= 1'b0;
      cnt_q       <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      breg_q      <= breg_d;
      cnt_q       <= cnt_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor
//   Directed bench for digit_serial_subtractor. Five instances share clk/rst
//   with DIGIT = 1, 2, 4, 8, 16 (index k -> DIGIT = 1 << k); WIDTH = 16.
//   Index 2 (DIGIT = 4) carries the handshake scenarios.
module tb_digit_serial_subtractor;

  localparam int unsigned W  = 16;
  localparam int          NI = 5;
  localparam int          NV = 9;
  localparam int          KM = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid_s  [NI];
  logic           in_ready_s  [NI];
  logic [W-1:0]   a_s         [NI];
  logic [W-1:0]   b_s         [NI];
  logic           bin_s       [NI];
  logic           out_valid_s [NI];
  logic           out_ready_s [NI];
  logic [W-1:0]   diff_s      [NI];
  logic           bout_s      [NI];
  logic           ovf_s       [NI];
  logic           busy_s      [NI];

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed vectors: a - b - bin mod 2^16, unsigned borrow, signed overflow.
  logic [W-1:0] tv_a   [NV] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF,
                                16'hFFFF, 16'h8000, 16'hA5A5, 16'h0000};
  logic [W-1:0] tv_b   [NV] = '{16'h0234, 16'h0001, 16'h0001, 16'h0005, 16'hFFFF,
                                16'h0000, 16'h7FFF, 16'h5A5A, 16'h0000};
  logic         tv_bin [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] tv_d   [NV] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000,
                                16'hFFFE, 16'h0000, 16'h4B4B, 16'hFFFF};
  logic         tv_bo  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic         tv_ov  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    digit_serial_subtractor #(
      .WIDTH(W),
      .DIGIT(32'd1 << g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .borrow_in (bin_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .diff      (diff_s[g]),
      .borrow_out(bout_s[g]),
      .overflow  (ovf_s[g]),
      .busy      (busy_s[g])
    );
  end

  // Issue one operation on instance k, wait for the result, then consume it.
  // n returns the number of edges from the accept edge to out_valid.
  task automatic run_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bv_in, output logic [W-1:0] d, output logic bo,
                        output logic ov, output int n);
    @(negedge clk);
    a_s[k] = av; b_s[k] = bv; bin_s[k] = bv_in; in_valid_s[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[k] = 1'b0;
    n = 0;
    while (!out_valid_s[k] && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    d = diff_s[k]; bo = bout_s[k]; ov = ovf_s[k];
    out_ready_s[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0; bin_s[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_vec++; if (in_ready_s[k] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready k=%0d got %b want 1", k, in_ready_s[k]); end
      n_vec++; if (out_valid_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid k=%0d got %b want 0", k, out_valid_s[k]); end
      n_vec++; if (busy_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_busy k=%0d got %b want 0", k, busy_s[k]); end
      n_vec++; if (diff_s[k] !== 16'h0000) begin n_err++; $display("FAIL reset_diff k=%0d got %h want 0000", k, diff_s[k]); end
      n_vec++; if (bout_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_borrow k=%0d got %b want 0", k, bout_s[k]); end
      n_vec++; if (ovf_s[k] !== 1'b0) begin n_err++; $display("FAIL reset_overflow k=%0d got %b want 0", k, ovf_s[k]); end
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] d; logic bo, ov; int n;
    for (int v = 0; v < NV; v++) begin
      run_op(KM, tv_a[v], tv_b[v], tv_bin[v], d, bo, ov, n);
      n_vec++; if (n !== 4) begin n_err++; $display("FAIL vec_latency v=%0d got %0d want 4", v, n); end
      n_vec++; if (d !== tv_d[v]) begin n_err++; $display("FAIL vec_diff v=%0d got %h want %h", v, d, tv_d[v]); end
      n_vec++; if (bo !== tv_bo[v]) begin n_err++; $display("FAIL vec_borrow v=%0d got %b want %b", v, bo, tv_bo[v]); end
      n_vec++; if (ov !== tv_ov[v]) begin n_err++; $display("FAIL vec_overflow v=%0d got %b want %b", v, ov, tv_ov[v]); end
    end
  endtask

  task automatic test_ignore_in_run();
    int n;
    @(negedge clk);
    a_s[KM] = 16'h8000; b_s[KM] = 16'h0001; bin_s[KM] = 1'b0; in_valid_s[KM] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Offer different operands and assert out_ready while running.
    a_s[KM] = 16'hFFFF; b_s[KM] = 16'hFFFF; bin_s[KM] = 1'b1; out_ready_s[KM] = 1'b1;
    n_vec++; if (in_ready_s[KM] !== 1'b0) begin n_err++; $display("FAIL run_in_ready got %b want 0", in_ready_s[KM]); end
    n = 0;
    while (!out_valid_s[KM] && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    in_valid_s[KM] = 1'b0; out_ready_s[KM] = 1'b0;
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL run_latency got %0d want 4", n); end
    n_vec++; if (diff_s[KM] !== 16'h7FFF) begin n_err++; $display("FAIL run_diff got %h want 7fff", diff_s[KM]); end
    n_vec++; if (bout_s[KM] !== 1'b0) begin n_err++; $display("FAIL run_borrow got %b want 0", bout_s[KM]); end
    n_vec++; if (ovf_s[KM] !== 1'b1) begin n_err++; $display("FAIL run_overflow got %b want 1", ovf_s[KM]); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (out_valid_s[KM] !== 1'b1) begin n_err++; $display("FAIL run_hold_valid got %b want 1", out_valid_s[KM]); end
    n_vec++; if (busy_s[KM] !== 1'b0) begin n_err++; $display("FAIL run_hold_busy got %b want 0", busy_s[KM]); end
    out_ready_s[KM] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_s[KM] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    a_s[KM] = 16'h1234; b_s[KM] = 16'h0234; bin_s[KM] = 1'b0; in_valid_s[KM] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[KM] = 1'b0;
    n = 0;
    while (!out_valid_s[KM] && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL bp_latency got %0d want 4", n); end
    // Next operation waits while the consumer stalls.
    a_s[KM] = 16'h0000; b_s[KM] = 16'h0001; bin_s[KM] = 1'b0; in_valid_s[KM] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if (out_valid_s[KM] !== 1'b1) begin n_err++; $display("FAIL bp_valid c=%0d got %b want 1", i, out_valid_s[KM]); end
      n_vec++; if (diff_s[KM] !== 16'h1000) begin n_err++; $display("FAIL bp_diff c=%0d got %h want 1000", i, diff_s[KM]); end
      n_vec++; if (bout_s[KM] !== 1'b0 || ovf_s[KM] !== 1'b0) begin n_err++; $display("FAIL bp_flags c=%0d got %b%b want 00", i, bout_s[KM], ovf_s[KM]); end
      n_vec++; if (in_ready_s[KM] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c=%0d got %b want 0", i, in_ready_s[KM]); end
    end
    out_ready_s[KM] = 1'b1;
    #1;
    n_vec++; if (in_ready_s[KM] !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b want 1", in_ready_s[KM]); end
    @(posedge clk);
    @(negedge clk);
    in_valid_s[KM] = 1'b0; out_ready_s[KM] = 1'b0;
    n_vec++; if (busy_s[KM] !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy_s[KM]); end
    n_vec++; if (out_valid_s[KM] !== 1'b0) begin n_err++; $display("FAIL b2b_valid got %b want 0", out_valid_s[KM]); end
    n_vec++; if (diff_s[KM] !== 16'h1000) begin n_err++; $display("FAIL b2b_diff_hold got %h want 1000", diff_s[KM]); end
    n = 0;
    while (!out_valid_s[KM] && n < 64) begin
      @(posedge clk); @(negedge clk); n++;
    end
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL b2b_latency got %0d want 4", n); end
    n_vec++; if (diff_s[KM] !== 16'hFFFF) begin n_err++; $display("FAIL b2b_diff got %h want ffff", diff_s[KM]); end
    n_vec++; if (bout_s[KM] !== 1'b1 || ovf_s[KM] !== 1'b0) begin n_err++; $display("FAIL b2b_flags got %b%b want 10", bout_s[KM], ovf_s[KM]); end
    out_ready_s[KM] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready_s[KM] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] d; logic bo, ov; int n;
    @(negedge clk);
    a_s[KM] = 16'hA5A5; b_s[KM] = 16'h5A5A; bin_s[KM] = 1'b0; in_valid_s[KM] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[KM] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy_s[KM] !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", busy_s[KM]); end
    n_vec++; if (diff_s[KM] !== 16'hFFFF) begin n_err++; $display("FAIL mid_diff_before got %h want ffff", diff_s[KM]); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid_s[KM] !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", out_valid_s[KM]); end
    n_vec++; if (busy_s[KM] !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy_s[KM]); end
    n_vec++; if (diff_s[KM] !== 16'h0000) begin n_err++; $display("FAIL mid_diff got %h want 0000", diff_s[KM]); end
    n_vec++; if (in_ready_s[KM] !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b want 1", in_ready_s[KM]); end
    @(negedge clk);
    rst = 1'b0;
    run_op(KM, 16'hA5A5, 16'h5A5A, 1'b0, d, bo, ov, n);
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL post_rst_latency got %0d want 4", n); end
    n_vec++; if (d !== 16'h4B4B) begin n_err++; $display("FAIL post_rst_diff got %h want 4b4b", d); end
    n_vec++; if (bo !== 1'b0 || ov !== 1'b1) begin n_err++; $display("FAIL post_rst_flags got %b%b want 01", bo, ov); end
  endtask

  task automatic test_digit_sweep();
    logic [W-1:0] d; logic bo, ov; int n;
    for (int k = 0; k < NI; k++) begin
      for (int v = 0; v < NV; v++) begin
        run_op(k, tv_a[v], tv_b[v], tv_bin[v], d, bo, ov, n);
        n_vec++; if (n !== (16 >> k)) begin n_err++; $display("FAIL sweep_latency k=%0d v=%0d got %0d want %0d", k, v, n, 16 >> k); end
        n_vec++; if (d !== tv_d[v]) begin n_err++; $display("FAIL sweep_diff k=%0d v=%0d got %h want %h", k, v, d, tv_d[v]); end
        n_vec++; if (bo !== tv_bo[v]) begin n_err++; $display("FAIL sweep_borrow k=%0d v=%0d got %b want %b", k, v, bo, tv_bo[v]); end
        n_vec++; if (ov !== tv_ov[v]) begin n_err++; $display("FAIL sweep_overflow k=%0d v=%0d got %b want %b", k, v, ov, tv_ov[v]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_digit_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
